// File: rtl/prs_word_packer.sv
// prs_word_packer
//   Packs qualified serial PRS bits into WIDTH-bit words, tags each word with
//   its ones-count, and buffers the words in a DEPTH-entry show-ahead FIFO
//   behind a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   in_bit     serial PRS bit
//   in_en      in_bit qualifier; a bit is consumed only when in_en=1
//   clear      synchronous flush of packer, FIFO and overflow flag
//   out_data   FIFO head word (0 while out_valid=0)
//   out_ones   popcount of head word (0 while out_valid=0)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head word
//   level      FIFO occupancy, 0..DEPTH
//   overflow   sticky; a completed word was dropped because the FIFO was full
module prs_word_packer #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_bit,
    input  logic                      in_en,
    input  logic                      clear,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(WIDTH):0]    out_ones,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam int OW = CW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [OW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    bcnt_q, bcnt_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic [OW-1:0]    ones_q [DEPTH];

    logic [WIDTH-1:0] sr_shift;
    logic [OW-1:0]    acc_next;
    logic             word_done;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], in_bit};
        end else begin
            sr_shift = {in_bit, sr_q[WIDTH-1:1]};
        end
        acc_next  = acc_q + {{(OW-1){1'b0}}, in_bit};
        word_done = in_en && (bcnt_q == CW'(WIDTH - 1));
        full      = (level_q == LW'(DEPTH));
        out_valid = (level_q != '0);
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        pop       = out_valid && out_ready && !clear;
        push      = word_done && (!full || pop) && !clear;
        drop      = word_done && full && !pop && !clear;
    end

    always_comb begin
        sr_d     = sr_q;
        acc_d    = acc_q;
        bcnt_d   = bcnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (clear) begin
            sr_d     = '0;
            acc_d    = '0;
            bcnt_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (in_en) begin
                sr_d = sr_shift;
                if (word_done) begin
                    acc_d  = '0;
                    bcnt_d = '0;
                end else begin
                    acc_d  = acc_next;
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q     <= '0;
            acc_q    <= '0;
            bcnt_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            bcnt_q   <= bcnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible when counted by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]  <= sr_shift;
            ones_q[wr_ptr_q] <= acc_next;
        end
    end

    always_comb begin
        out_data = out_valid ? mem_q[rd_ptr_q]  : '0;
        out_ones = out_valid ? ones_q[rd_ptr_q] : '0;
        level    = level_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_prs_word_packer.sv
// tb_prs_word_packer
//   Drives an MSB-first and an LSB-first packer with the same serial stream.
//   Word-level vector table, hand sequences for FIFO full/overflow/clear/reset,
//   then randomized traffic against a queue-based reference model.
module tb_prs_word_packer;

    localparam int W = 16;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_bit;
    logic       in_en;
    logic       clear;
    logic       out_ready;

    logic [15:0] d1_data,  d0_data;
    logic [4:0]  d1_ones,  d0_ones;
    logic        d1_valid, d0_valid;
    logic [2:0]  d1_level, d0_level;
    logic        d1_ovf,   d0_ovf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending bits in arrival order, FIFO contents per view.
    bit          m_bits[$];
    logic [15:0] m_f1[$];
    logic [15:0] m_f0[$];
    bit          m_ovf;

    always #5 clk = ~clk;

    prs_word_packer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en), .clear(clear),
        .out_data(d1_data), .out_ones(d1_ones), .out_valid(d1_valid),
        .out_ready(out_ready), .level(d1_level), .overflow(d1_ovf)
    );

    prs_word_packer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en), .clear(clear),
        .out_data(d0_data), .out_ones(d0_ones), .out_valid(d0_valid),
        .out_ready(out_ready), .level(d0_level), .overflow(d0_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_f1.delete();
        m_f0.delete();
        m_ovf = 1'b0;
    endtask

    // Applies the rules to the inputs present at the edge just taken.
    task automatic model_step();
        bit          pop;
        bit          done;
        int          sz;
        logic [15:0] w1;
        logic [15:0] w0;
        w1 = '0;
        w0 = '0;
        if (clear) begin
            model_reset();
        end else begin
            sz   = m_f1.size();
            pop  = (sz > 0) && out_ready;
            done = 1'b0;
            if (in_en) begin
                m_bits.push_back(in_bit);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        w1[W-1-i] = m_bits[i];
                        w0[i]     = m_bits[i];
                    end
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (pop) begin
                void'(m_f1.pop_front());
                void'(m_f0.pop_front());
            end
            if (done) begin
                if (sz < D || pop) begin
                    m_f1.push_back(w1);
                    m_f0.push_back(w0);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic        v;
        logic [15:0] h1, h0;
        logic [4:0]  e1, e0;
        logic [2:0]  lv;
        v  = (m_f1.size() != 0);
        h1 = v ? m_f1[0] : 16'h0;
        h0 = v ? m_f0[0] : 16'h0;
        e1 = 5'($countones(h1));
        e0 = 5'($countones(h0));
        lv = 3'(m_f1.size());
        chk("model_msb", {6'h0, d1_valid, d1_data, d1_ones, d1_level, d1_ovf},
                         {6'h0, v, h1, e1, lv, m_ovf});
        chk("model_lsb", {6'h0, d0_valid, d0_data, d0_ones, d0_level, d0_ovf},
                         {6'h0, v, h0, e0, lv, m_ovf});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        check_model();
        chk("reset_valid", d1_valid, 0);
        chk("reset_level", d1_level, 0);
        #2;
        rst = 1'b1;
    endtask

    // Feeds the first nb bits of w, bit 15 first; gap[k] inserts two
    // unqualified cycles (with in_bit toggling) after the k-th fed bit.
    task automatic feed_word(input logic [15:0] w, input logic [15:0] gap, input int nb);
        for (int k = 0; k < nb; k++) begin
            in_bit = w[15-k];
            in_en  = 1'b1;
            tick();
            if (gap[k]) begin
                for (int g = 0; g < 2; g++) begin
                    in_en  = 1'b0;
                    in_bit = ~in_bit;
                    tick();
                end
            end
        end
        in_en = 1'b0;
    endtask

    typedef struct {
        logic [15:0] seq;
        logic [15:0] gap;
        logic [15:0] exp_msb;
        logic [15:0] exp_lsb;
        int          ones;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [15:0] exp_q[4];

        tbl[0] = '{16'hACE1, 16'h0000, 16'hACE1, 16'h8735, 8};
        tbl[1] = '{16'h8735, 16'h0104, 16'h8735, 16'hACE1, 8};
        tbl[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16};
        tbl[3] = '{16'h0000, 16'h0421, 16'h0000, 16'h0000, 0};
        tbl[4] = '{16'h1234, 16'h0010, 16'h1234, 16'h2C48, 5};
        tbl[5] = '{16'h0001, 16'h0000, 16'h0001, 16'h8000, 1};

        rst       = 1'b0;
        in_bit    = 1'b0;
        in_en     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_model();
        chk("reset_data", d1_data, 0);
        chk("reset_ovf", d1_ovf, 0);
        rst = 1'b1;

        // Word-level vectors, consumer always ready.
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            feed_word(tbl[t].seq, tbl[t].gap, 16);
            chk($sformatf("tbl%0d_valid", t), d1_valid, 1);
            chk($sformatf("tbl%0d_msb_data", t), d1_data, tbl[t].exp_msb);
            chk($sformatf("tbl%0d_lsb_data", t), d0_data, tbl[t].exp_lsb);
            chk($sformatf("tbl%0d_msb_ones", t), d1_ones, tbl[t].ones);
            chk($sformatf("tbl%0d_lsb_ones", t), d0_ones, tbl[t].ones);
            chk($sformatf("tbl%0d_level", t), d1_level, 1);
            tick();
            chk($sformatf("tbl%0d_popped", t), d1_valid, 0);
            chk($sformatf("tbl%0d_level0", t), d1_level, 0);
        end

        // Overflow: fifth word dropped, first four drain in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            feed_word(16'(i), 16'h0, 16);
            if (i == 4) chk("ovf_before_5th", d1_ovf, 0);
        end
        chk("ovf_level", d1_level, 4);
        chk("ovf_flag", d1_ovf, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), d1_data, i);
            tick();
        end
        chk("ovf_drained_valid", d1_valid, 0);
        chk("ovf_sticky", d1_ovf, 1);

        // Clear with level=3 and overflow set; clear edge ignores in_en and pop.
        out_ready = 1'b0;
        feed_word(16'h000A, 16'h0, 16);
        feed_word(16'h000B, 16'h0, 16);
        feed_word(16'h000C, 16'h0, 16);
        chk("clr_pre_level", d1_level, 3);
        clear     = 1'b1;
        in_en     = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b1;
        tick();
        clear = 1'b0;
        in_en = 1'b0;
        chk("clr_level", d1_level, 0);
        chk("clr_valid", d1_valid, 0);
        chk("clr_data", d1_data, 0);
        chk("clr_ovf", d1_ovf, 0);
        feed_word(16'h1234, 16'h0, 16);
        chk("clr_word", d1_data, 16'h1234);
        chk("clr_ones", d1_ones, 5);
        tick();

        // Full FIFO with pop on the edge the next word completes.
        out_ready = 1'b0;
        feed_word(16'h0011, 16'h0, 16);
        feed_word(16'h0022, 16'h0, 16);
        feed_word(16'h0033, 16'h0, 16);
        feed_word(16'h0044, 16'h0, 16);
        chk("full_level", d1_level, 4);
        feed_word(16'h00FF, 16'h0, 15);
        out_ready = 1'b1;
        in_bit    = 1'b1;
        in_en     = 1'b1;
        tick();
        in_en = 1'b0;
        chk("full_pp_level", d1_level, 4);
        chk("full_pp_ovf", d1_ovf, 0);
        exp_q = '{16'h0022, 16'h0033, 16'h0044, 16'h00FF};
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("full_drain%0d", j), d1_data, exp_q[j]);
            tick();
        end
        chk("full_empty", d1_valid, 0);

        // Reset mid-word: partial bits are lost.
        feed_word(16'h5A5A, 16'h0, 7);
        do_reset();
        out_ready = 1'b1;
        feed_word(16'hFFFF, 16'h0, 16);
        chk("rst_word_valid", d1_valid, 1);
        chk("rst_word_data", d1_data, 16'hFFFF);
        chk("rst_word_ones", d1_ones, 16);
        chk("rst_word_lsb", d0_data, 16'hFFFF);
        tick();
        chk("rst_single_word", d1_valid, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end
            in_bit    = 1'($urandom);
            in_en     = ($urandom_range(0, 9) < 7);
            out_ready = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 299) == 0);
            tick();
        end
        clear = 1'b0;
        in_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prs_word_packer.md
Name: prs_word_packer

Overview:
- Downstream consumer of the PRS 1-bit pseudo-random stream.
- Qualified serial bits are packed into WIDTH-bit words. Each word is tagged with its ones-count, a cheap per-word monobit statistic.
- Words are buffered in a DEPTH-entry show-ahead FIFO behind a valid/ready handshake, so wider consumers (RANDOM-style word sinks, loggers) can absorb PRS output at their own pace.

Parameters:
- WIDTH, 16, word width in bits; >= 2.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- MSB_FIRST, 1, 1: first received bit lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- in_bit  in  1  serial PRS bit.
- in_en  in  1  in_bit qualifier; a bit is consumed only on edges where in_en=1.
- clear  in  1  synchronous flush.
- out_data  out  WIDTH  FIFO head word.
- out_ones  out  $clog2(WIDTH)+1  popcount of head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset (rst=0, async): bit counter, shift register, ones accumulator, FIFO pointers, level and overflow all go to 0. Outputs: out_valid=0, out_data=0, out_ones=0, level=0, overflow=0.
- out_data and out_ones are forced to 0 whenever out_valid=0.
- Packer, per edge with in_en=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], in_bit}.
  - MSB_FIRST=0: sr <= {in_bit, sr[WIDTH-1:1]}.
  - acc <= acc + in_bit; bcnt increments.
  - in_en=0 edges: no change to sr, acc or bcnt.
- Word completion: an edge with in_en=1 and bcnt==WIDTH-1.
  - The post-shift word and acc+in_bit form the push candidate.
  - bcnt and acc return to 0 on that same edge.
- Push rules:
  - Candidate is written if level<DEPTH, or if level==DEPTH and a pop occurs on the same edge.
  - Otherwise the word is discarded and overflow is set to 1.
  - Packing continues regardless of FIFO state.
- Pop: occurs on an edge where out_valid=1 and out_ready=1. Head advances; the next entry is visible on the following cycle (show-ahead).
- Latency:
  - Completing bit sampled at edge N → out_valid=1 and the word on out_data after edge N (visible in cycle N+1).
  - No combinational bypass from in_bit to out_data.
- Level accounting:
  - Push only: level+1. Pop only: level-1.
  - Push and pop on the same edge: level unchanged, including at level==0? No — at level==0 there is no pop (out_valid=0), so it is a push only.
  - At level==DEPTH with pop, the push succeeds.
- Pointers: rd_ptr/wr_ptr wrap modulo DEPTH; full and empty are derived from level, not from pointer equality.
- clear=1 (synchronous):
  - Next edge: level=0, pointers=0, bcnt=0, acc=0, sr=0, overflow=0.
  - in_en, push and pop on that edge are ignored; clear has priority over everything except rst.
- Reset mid-word: partial word is lost. The first word after release consists of the first WIDTH qualified bits after release.
- overflow clears only on rst or clear.
- out_ready while out_valid=0: no effect.

Test Plan:
- WIDTH=16, MSB_FIRST=1, out_ready=1: feed 0xACE1 MSB-first with in_en=1 → out_valid=1 for one cycle after the 16th bit edge, out_data=0xACE1, out_ones=8, level returns to 0 after pop.
- MSB_FIRST=0: feed 0xACE1 LSB-first, with in_en=0 gaps inserted after bits 3 and 9 (in_bit toggling during gaps) → out_data=0xACE1, out_ones=8; gap bits ignored.
- out_ready=0, DEPTH=4: push words 0x0001, 0x0002, 0x0003, 0x0004, 0x0005 → level=4, overflow=1 after the 5th word; then out_ready=1 → pops 0x0001..0x0004 in order, 0x0005 never appears, overflow stays 1.
- Full FIFO (level=4), out_ready=1 on the same edge the next word 0x00FF completes → level stays 4, overflow stays 0, 0x00FF emerges 4th after the current head.
- Assert rst low after 7 bits, release, feed 16 ones → single word 0xFFFF, out_ones=16; no word containing the pre-reset bits.
- level=3, overflow=1, clear pulsed for one cycle → next cycle level=0, out_valid=0, out_data=0, overflow=0; a subsequent 16-bit word 0x1234 emerges with out_ones=5.
